seq_detect_param: RTL and testbench

//  Parametrised Mealy serial-pattern detector, successor to the fixed 4-bit "1011" detector.
//  - Pattern value and length are parameters; the pattern can also be reloaded at runtime.
//  - Overlapping or non-overlapping detection is selectable.
//  - Input is qualified by a valid strobe.
//  - A saturating match counter is kept.
//  - Sits on a serial bit stream (UART/line decoder output) and flags frame-sync words.

---
 rtl/seq_detect_param.sv | 86 ++++++++
 tb/tb_seq_detect_param.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Parametrised Mealy serial-pattern detector with runtime pattern reload,
// selectable overlap, valid-qualified input and a saturating match counter.
module seq_detect_param #(
  parameter int                   PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0]   PATTERN = 4'b1011,
  parameter bit                   OVERLAP = 1'b1,
  parameter int                   CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  input  logic               cnt_clr,
  output logic               dout,
  output logic [CNT_W-1:0]   match_count
);

  localparam int               FILL_W   = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [PAT_LEN-1:0] pattern_q, pattern_d;
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               dout_q, dout_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Candidate window: the stored history with the incoming bit appended as newest.
  logic [PAT_LEN-1:0] window;
  logic               match;

  assign window = {hist_q, din};
  assign match  = din_valid & ~pat_load & (window == pattern_q) & (fill_q == FILL_MAX);

  always_comb begin
    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    dout_d    = 1'b0;
    if (pat_load) begin
      pattern_d = pat_in;
      hist_d    = '0;
      fill_d    = '0;
    end else if (din_valid) begin
      hist_d = window[PAT_LEN-2:0];
      dout_d = match;
      if (!match) begin
        fill_d = (fill_q == FILL_MAX) ? fill_q : fill_q + FILL_W'(1);
      end else if (!OVERLAP) begin
        // Non-overlapping: the search restarts, so the old history is ignored until refilled.
        fill_d = '0;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (cnt_clr) begin
      count_d = '0;
    end else if (match && (count_q != CNT_MAX)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q <= PATTERN;
      hist_q    <= '0;
      fill_q    <= '0;
      dout_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      dout_q    <= dout_d;
      count_q   <= count_d;
    end
  end

  assign dout        = dout_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: overlapping, non-overlapping, saturating
// and 2-bit instances share one stimulus bus; each scenario checks its instance.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic [1:0] pat_in2 = 2'b11;
  logic       cnt_clr = 1'b0;

  logic       dout_ov, dout_nov, dout_sat, dout_p2;
  logic [7:0] cnt_ov, cnt_nov, cnt_p2;
  logic [1:0] cnt_sat;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .dout(dout_ov), .match_count(cnt_ov));

  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .dout(dout_nov), .match_count(cnt_nov));

  seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .pat_load(pat_load),
    .pat_in(pat_in), .cnt_clr(cnt_clr), .dout(dout_sat), .match_count(cnt_sat));

  seq_detect_param #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(8)) u_p2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .pat_load(pat_load),
    .pat_in(pat_in2), .cnt_clr(cnt_clr), .dout(dout_p2), .match_count(cnt_p2));

  // One clock: apply din/din_valid, let the edge happen, sample 1 time unit later.
  task automatic step(input logic v, input logic b);
    din_valid = v;
    din       = b;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    din       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cnt_clr = 1'b0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    reset = 1'b0;
    total_cnt++;
    if ({dout_ov, dout_nov, dout_sat, dout_p2} !== 4'b0000)
      $display("FAIL reset_dout: got %b expected 0000", {dout_ov, dout_nov, dout_sat, dout_p2});
    else pass_cnt++;
    total_cnt++;
    if ({cnt_ov, cnt_nov, cnt_sat, cnt_p2} !== 26'd0)
      $display("FAIL reset_count: got ov=%0d nov=%0d sat=%0d p2=%0d expected all 0",
               cnt_ov, cnt_nov, cnt_sat, cnt_p2);
    else pass_cnt++;
  endtask

  task automatic test_overlap();
    logic [6:0] s     = 7'b1011011;
    logic [6:0] e_ov  = 7'b0001001;
    logic [6:0] e_nov = 7'b0001000;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, s[i]);
      total_cnt++;
      if (dout_ov !== e_ov[i])
        $display("FAIL overlap_dout bit%0d: got %b expected %b", 7 - i, dout_ov, e_ov[i]);
      else pass_cnt++;
      total_cnt++;
      if (dout_nov !== e_nov[i])
        $display("FAIL nonoverlap_dout bit%0d: got %b expected %b", 7 - i, dout_nov, e_nov[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (cnt_ov !== 8'd2) $display("FAIL overlap_count: got %0d expected 2", cnt_ov);
    else pass_cnt++;
    total_cnt++;
    if (cnt_nov !== 8'd1) $display("FAIL nonoverlap_count: got %0d expected 1", cnt_nov);
    else pass_cnt++;
  endtask

  task automatic test_non_overlap();
    logic [10:0] s     = 11'b10110111011;
    logic [10:0] e_ov  = 11'b00010010001;
    logic [10:0] e_nov = 11'b00010000001;
    do_reset();
    for (int i = 10; i >= 0; i--) begin
      step(1'b1, s[i]);
      total_cnt++;
      if (dout_nov !== e_nov[i])
        $display("FAIL nonoverlap_long bit%0d: got %b expected %b", 11 - i, dout_nov, e_nov[i]);
      else pass_cnt++;
      total_cnt++;
      if (dout_ov !== e_ov[i])
        $display("FAIL overlap_long bit%0d: got %b expected %b", 11 - i, dout_ov, e_ov[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (cnt_nov !== 8'd2) $display("FAIL nonoverlap_long_count: got %0d expected 2", cnt_nov);
    else pass_cnt++;
    total_cnt++;
    if (cnt_ov !== 8'd3) $display("FAIL overlap_long_count: got %0d expected 3", cnt_ov);
    else pass_cnt++;
  endtask

  task automatic test_valid_gap();
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1);
      total_cnt++;
      if (dout_ov !== 1'b0) $display("FAIL gap_dout cycle%0d: got %b expected 0", i, dout_ov);
      else pass_cnt++;
    end
    step(1'b1, 1'b1);
    total_cnt++;
    if (dout_ov !== 1'b1) $display("FAIL gap_final_dout: got %b expected 1", dout_ov);
    else pass_cnt++;
    step(1'b0, 1'b0);
    total_cnt++;
    if (dout_ov !== 1'b0) $display("FAIL gap_pulse_width: got %b expected 0", dout_ov);
    else pass_cnt++;
  endtask

  task automatic test_pat_load();
    logic [3:0] s = 4'b0110;
    logic [3:0] e = 4'b0001;
    do_reset();
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    pat_load = 1'b1;
    pat_in   = 4'b0110;
    step(1'b1, 1'b1);
    pat_load = 1'b0;
    total_cnt++;
    if (dout_ov !== 1'b0) $display("FAIL load_drops_din: got %b expected 0", dout_ov);
    else pass_cnt++;
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, s[i]);
      total_cnt++;
      if (dout_ov !== e[i])
        $display("FAIL load_new_pattern bit%0d: got %b expected %b", 4 - i, dout_ov, e[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (cnt_ov !== 8'd1) $display("FAIL load_count: got %0d expected 1", cnt_ov);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    logic [9:0] e = 10'b0001111111;
    do_reset();
    for (int i = 9; i >= 0; i--) begin
      step(1'b1, 1'b1);
      total_cnt++;
      if (dout_sat !== e[i])
        $display("FAIL sat_dout bit%0d: got %b expected %b", 10 - i, dout_sat, e[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (cnt_sat !== 2'd3) $display("FAIL sat_count: got %0d expected 3", cnt_sat);
    else pass_cnt++;
    cnt_clr = 1'b1;
    step(1'b1, 1'b1);
    cnt_clr = 1'b0;
    total_cnt++;
    if (dout_sat !== 1'b1) $display("FAIL clr_match_dout: got %b expected 1", dout_sat);
    else pass_cnt++;
    total_cnt++;
    if (cnt_sat !== 2'd0) $display("FAIL clr_wins_count: got %0d expected 0", cnt_sat);
    else pass_cnt++;
    step(1'b1, 1'b1);
    total_cnt++;
    if (cnt_sat !== 2'd1) $display("FAIL count_after_clr: got %0d expected 1", cnt_sat);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [4:0] e = 5'b01111;
    do_reset();
    for (int i = 4; i >= 0; i--) begin
      step(1'b1, 1'b1);
      total_cnt++;
      if (dout_p2 !== e[i])
        $display("FAIL b2b_dout bit%0d: got %b expected %b", 5 - i, dout_p2, e[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (cnt_p2 !== 8'd4) $display("FAIL b2b_count: got %0d expected 4", cnt_p2);
    else pass_cnt++;
    pat_load = 1'b1;
    pat_in2  = 2'b01;
    step(1'b0, 1'b0);
    pat_load = 1'b0;
    step(1'b1, 1'b0);
    total_cnt++;
    if (dout_p2 !== 1'b0) $display("FAIL p2_load_first: got %b expected 0", dout_p2);
    else pass_cnt++;
    step(1'b1, 1'b1);
    total_cnt++;
    if (dout_p2 !== 1'b1) $display("FAIL p2_load_match: got %b expected 1", dout_p2);
    else pass_cnt++;
    pat_in2 = 2'b11;
  endtask

  task automatic test_reset_mid();
    logic [5:0] s = 6'b101101;
    logic [3:0] e = 4'b0001;
    do_reset();
    for (int i = 5; i >= 0; i--) step(1'b1, s[i]);
    total_cnt++;
    if (cnt_ov !== 8'd1) $display("FAIL pre_reset_count: got %0d expected 1", cnt_ov);
    else pass_cnt++;
    reset = 1'b1;
    step(1'b1, 1'b1);
    reset = 1'b0;
    total_cnt++;
    if (dout_ov !== 1'b0) $display("FAIL midreset_dout: got %b expected 0", dout_ov);
    else pass_cnt++;
    total_cnt++;
    if (cnt_ov !== 8'd0) $display("FAIL midreset_count: got %0d expected 0", cnt_ov);
    else pass_cnt++;
    s = 6'b001011;
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, s[i]);
      total_cnt++;
      if (dout_ov !== e[i])
        $display("FAIL post_reset bit%0d: got %b expected %b", 4 - i, dout_ov, e[i]);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_valid_gap();
    test_pat_load();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
